// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM states and the default datapath width.
package mul_div_unit_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/cla32.sv
// Carry-lookahead adder with carry-in: per-bit generate/propagate cells grouped
// into 4-bit lookahead blocks whose block carries ripple.
module cla32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    localparam int unsigned NBLK = WIDTH / 4;

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH:0]   w_c;

    assign w_g = i_x & i_y;
    assign w_p = i_x ^ i_y;

    // Every carry inside a block is expanded from the block's incoming carry only
    always_comb begin
        w_c    = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < NBLK; i++) begin
            w_c[4*i+1] = w_g[4*i] | (w_p[4*i] & w_c[4*i]);
            w_c[4*i+2] = w_g[4*i+1] | (w_p[4*i+1] & w_g[4*i])
                       | (w_p[4*i+1] & w_p[4*i] & w_c[4*i]);
            w_c[4*i+3] = w_g[4*i+2] | (w_p[4*i+2] & w_g[4*i+1])
                       | (w_p[4*i+2] & w_p[4*i+1] & w_g[4*i])
                       | (w_p[4*i+2] & w_p[4*i+1] & w_p[4*i] & w_c[4*i]);
            w_c[4*i+4] = w_g[4*i+3] | (w_p[4*i+3] & w_g[4*i+2])
                       | (w_p[4*i+3] & w_p[4*i+2] & w_g[4*i+1])
                       | (w_p[4*i+3] & w_p[4*i+2] & w_p[4*i+1] & w_g[4*i])
                       | (w_p[4*i+3] & w_p[4*i+2] & w_p[4*i+1] & w_p[4*i] & w_c[4*i]);
        end
    end

    assign o_sum  = w_p ^ w_c[WIDTH-1:0];
    assign o_cout = w_c[WIDTH];

endmodule

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle through a shared carry-lookahead adder, sign fix-up at the end.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_hi_we,
    input  logic             i_lo_we,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int unsigned   CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [CW-1:0]    r_cnt;
    op_e              r_op;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_dz;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mq;
    logic [WIDTH-1:0] r_opd;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_div_zero;

    logic             w_start_div;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    assign w_start_div = i_op[1];
    assign w_neg_a     = i_op[0] & i_a[WIDTH-1];
    assign w_neg_b     = i_op[0] & i_b[WIDTH-1];
    assign w_abs_a     = w_neg_a ? -i_a : i_a;
    assign w_abs_b     = w_neg_b ? -i_b : i_b;

    logic             w_is_div;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_cla_x;
    logic [WIDTH-1:0] w_cla_y;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic [WIDTH:0]   w_madd;
    logic             w_ge;

    assign w_is_div = (r_op == OP_DIVU) || (r_op == OP_DIV);
    assign w_shift  = {r_acc[WIDTH-2:0], r_mq[WIDTH-1]};
    // Divide subtracts the divisor from the shifted remainder; multiply adds the multiplicand
    assign w_cla_x  = w_is_div ? w_shift : r_acc;
    assign w_cla_y  = w_is_div ? ~r_opd : r_opd;

    cla32 #(
        .WIDTH (WIDTH)
    ) u_cla (
        .i_x    (w_cla_x),
        .i_y    (w_cla_y),
        .i_cin  (w_is_div),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_madd = r_mq[0] ? {w_cout, w_sum} : {1'b0, r_acc};
    // The shifted remainder is 33 bits wide; its dropped MSB alone guarantees it fits
    assign w_ge   = r_acc[WIDTH-1] | w_cout;

    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_hi_fix;
    logic [WIDTH-1:0]   w_lo_fix;

    always_comb begin
        w_prod     = {r_acc, r_mq};
        w_prod_fix = (r_sign_a ^ r_sign_b) ? -w_prod : w_prod;
        w_hi_fix   = w_prod_fix[2*WIDTH-1:WIDTH];
        w_lo_fix   = w_prod_fix[WIDTH-1:0];
        if (w_is_div) begin
            w_lo_fix = (r_sign_a ^ r_sign_b) ? -r_mq : r_mq;
            w_hi_fix = r_sign_a ? -r_acc : r_acc;
            if (r_dz) begin
                w_lo_fix = '1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_state_next = ST_CALC;
            ST_CALC: if (r_cnt == CNT_LAST) w_state_next = ST_FIX;
            ST_FIX:  w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_op       <= OP_MULTU;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_dz       <= 1'b0;
            r_acc      <= '0;
            r_mq       <= '0;
            r_opd      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_op     <= op_e'(i_op);
                        r_sign_a <= w_neg_a;
                        r_sign_b <= w_neg_b;
                        r_dz     <= w_start_div & (i_b == '0);
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_mq     <= w_start_div ? w_abs_a : w_abs_b;
                        r_opd    <= w_start_div ? w_abs_b : w_abs_a;
                    end else begin
                        if (i_hi_we) r_hi <= i_wdata;
                        if (i_lo_we) r_lo <= i_wdata;
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_is_div) begin
                        r_acc <= w_ge ? w_sum : w_shift;
                        r_mq  <= {r_mq[WIDTH-2:0], w_ge};
                    end else begin
                        r_acc <= w_madd[WIDTH:1];
                        r_mq  <= {w_madd[0], r_mq[WIDTH-1:1]};
                    end
                end
                // Results land in HI/LO together with the done pulse of the DONE cycle
                ST_FIX: begin
                    r_hi       <= w_hi_fix;
                    r_lo       <= w_lo_fix;
                    r_done     <= 1'b1;
                    r_div_zero <= r_dz;
                end
                default: ;
            endcase
        end
    end

    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = r_done;
    assign o_div_zero = r_div_zero;
    assign o_hi       = r_hi;
    assign o_lo       = r_lo;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; all values below assume 32.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request new operation, sampled only in IDLE.
REQ-005 SHALL have port op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port a  input  32  multiplicand / dividend (rs).
REQ-007 SHALL have port b  input  32  multiplier / divisor (rt).
REQ-008 SHALL have port hi_we, lo_we  input  1 each  MTHI / MTLO write strobes.
REQ-009 SHALL have port wdata  input  32  MTHI/MTLO data.
REQ-010 SHALL have port busy  output  1  high from cycle after accepted start until done cycle inclusive.
REQ-011 SHALL have port done  output  1  one-cycle pulse, results valid on hi/lo.
REQ-012 SHALL have port div_zero  output  1  pulses with done when divisor was zero.
REQ-013 SHALL have port hi, lo  output  32 each  HI/LO architectural registers.

Function
REQ-014 SHALL implement FSM IDLE -> CALC -> FIX -> DONE -> IDLE.
REQ-015 IDLE: start=1 SHALL latch op, |a|, |b| (signed ops), operand signs; next state CALC; counter=0.
REQ-016 CALC SHALL run exactly 32 cycles: multiply = shift-add (1 bit/cycle), divide = restoring (1 quotient bit/cycle), all add/sub through the cla32 sub-module.
REQ-017 FIX (1 cycle): signed MULT SHALL negate 64-bit product if signs differ; DIV SHALL negate quotient if signs differ, remainder if dividend negative.
REQ-018 DONE SHALL write HI/LO and assert done for one cycle; start-to-done latency = 34 cycles (start sampled cycle 0, done cycle 34).
REQ-019 MULT/MULTU: HI = product[63:32], LO = product[31:0].
REQ-020 DIV/DIVU: LO = quotient, HI = remainder; remainder sign = dividend sign.
REQ-021 Divisor zero: LO = 0xFFFFFFFF, HI = a (as latched, unmodified), div_zero = 1 with done; same 34-cycle latency.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0x00000000, no flag.
REQ-023 start while busy SHALL be ignored; no queuing.
REQ-024 hi_we/lo_we in IDLE SHALL write wdata next edge; while busy SHALL be ignored.
REQ-025 start and hi_we/lo_we same IDLE cycle: start accepted, writes dropped.
REQ-026 hi/lo SHALL hold previous values throughout CALC/FIX; update only in DONE.
REQ-027 Inputs a, b, op SHALL only be sampled on accepted start.

Reset
REQ-028 rst=1 at any clk edge, any state, SHALL force IDLE, counter 0, hi=lo=0, busy=done=div_zero=0.
REQ-029 Reset mid-operation SHALL abandon the operation with no done pulse.

Structure
REQ-030 Shared package SHALL hold op encodings (OP_MULTU..OP_DIV), FSM state encodings, WIDTH default.
REQ-031 SHALL instantiate one sub-module cla32 (32-bit carry-lookahead adder with carry-in, built from the existing generate/propagate cells), used for add and subtract (invert + cin=1).
REQ-032 Only registered outputs; no combinational path from inputs to outputs.

Verification
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> cycle 34 done=1, HI=0xFFFFFFFE, LO=0x00000001.
REQ-034 MULT 0xFFFFFFFD (-3) x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-035 DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-036 DIVU 0x1234 / 0 -> done+div_zero cycle 34, LO=0xFFFFFFFF, HI=0x00001234; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-037 start at cycle 10 of running op and hi_we during busy -> ignored, single done, HI/LO = first op result.
REQ-038 rst at cycle 15 of MULT -> next cycle busy=0, hi=lo=0, no done; new start then completes normally.
